// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_FAST_SPECIAL_EN lets divide-by-zero and signed overflow bypass CALC.
module mul_div_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a_orig;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic              r_neg;
    logic              r_div0;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_result;

    // Operand conditioning at the accepting edge
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;

    assign w_sign_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_sign_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg   = w_sign_a & rs1_data[XLEN-1];
    assign w_b_neg   = w_sign_b & rs2_data[XLEN-1];
    assign w_a_mag   = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag   = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;
    // A remainder follows only the dividend's sign; everything else follows the sign product.
    assign w_neg     = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0    = op[2] && (rs2_data == '0);
    assign w_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                       (rs1_data == MOST_NEG) && (rs2_data == '1);
    assign w_special = w_div0 || w_ovf;

    // Iteration datapaths
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN+1:0]   w_div_diff;
    logic              w_div_borrow;

    assign w_mul_sum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opa} : '0);
    assign w_div_diff   = {r_rem, r_quo[XLEN-1]} - {2'b00, r_opb};
    assign w_div_borrow = w_div_diff[XLEN+1];

    // Sign correction and output selection
    logic [2*XLEN-1:0] w_prod_signed;
    logic [XLEN-1:0]   w_quo_signed;
    logic [XLEN-1:0]   w_rem_signed;
    logic [XLEN-1:0]   w_fix_result;

    assign w_prod_signed = r_neg ? (~r_prod + 1'b1) : r_prod;
    assign w_quo_signed  = r_neg ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_signed  = r_neg ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

    always_comb begin
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                      w_fix_result = r_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (r_div0)      w_fix_result = '1;
                else if (r_ovf)  w_fix_result = MOST_NEG;
                else             w_fix_result = w_quo_signed;
            end
            OP_REM, OP_REMU: begin
                if (r_div0)      w_fix_result = r_a_orig;
                else if (r_ovf)  w_fix_result = '0;
                else             w_fix_result = w_rem_signed;
            end
            default:                     w_fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef MULDIV_FAST_SPECIAL_EN
                    w_state_next = w_special ? S_FIX : S_CALC;
`else
                    w_state_next = S_CALC;
`endif
                end
            end
            S_CALC:  if (r_cnt == CNT_LAST) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_a_orig <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_neg    <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a_orig <= rs1_data;
                        r_opa    <= w_a_mag;
                        r_opb    <= w_b_mag;
                        r_prod   <= {{XLEN{1'b0}}, w_b_mag};
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_neg    <= w_neg;
                        r_div0   <= w_div0;
                        r_ovf    <= w_ovf;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op[2]) begin
                        if (w_div_borrow) begin
                            r_rem <= {r_rem[XLEN-1:0], r_quo[XLEN-1]};
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end else begin
                            r_rem <= w_div_diff[XLEN:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end
                    end else begin
                        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
                    end
                end
                S_FIX:   r_result <= w_fix_result;
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: result values, latency, done pulse width,
// start-while-busy handling, back-to-back issue and mid-operation reset.
module tb_mul_div_unit;

    localparam int XLEN     = 64;
    localparam int FULL_LAT = XLEN + 2;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = XLEN + 2;
`endif
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        special;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation from the current (post-edge) time; lat counts edges
    // starting with the accepting edge until done is seen.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat,
                          output logic busy_after_accept, output logic idle_after_done);
        op = o; rs1_data = a; rs2_data = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_after_accept = busy;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
        idle_after_done = !done && !busy;
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        logic        b_ok;
        logic        i_ok;
        logic        saw_done;

        vecs.push_back('{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
        vecs.push_back('{3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{3'd1, ONES, ONES, 64'd0, 1'b0});
        vecs.push_back('{3'd2, ONES, 64'd2, ONES, 1'b0});
        vecs.push_back('{3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0});
        vecs.push_back('{3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{3'd5, 64'd20, 64'd3, 64'd6, 1'b0});
        vecs.push_back('{3'd7, 64'd20, 64'd3, 64'd2, 1'b0});
        vecs.push_back('{3'd4, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0});
        vecs.push_back('{3'd6, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 1'b0});
        vecs.push_back('{3'd4, MNEG, ONES, MNEG, 1'b1});
        vecs.push_back('{3'd6, MNEG, ONES, 64'd0, 1'b1});
        vecs.push_back('{3'd5, 64'h1234, 64'd0, ONES, 1'b1});
        vecs.push_back('{3'd7, 64'h1234, 64'd0, 64'h1234, 1'b1});
        vecs.push_back('{3'd4, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 1'b1});
        vecs.push_back('{3'd6, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1});
        vecs.push_back('{3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0});
        vecs.push_back('{3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0});
        vecs.push_back('{3'd5, 64'd0, 64'd7, 64'd0, 1'b0});
        vecs.push_back('{3'd1, MNEG, MNEG, 64'h4000_0000_0000_0000, 1'b0});
        vecs.push_back('{3'd5, 64'd7, 64'd7, 64'd1, 1'b0});
        vecs.push_back('{3'd2, MNEG, ONES, MNEG, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", result, 64'd0);

        // Consecutive calls issue each new start in the cycle right after DONE.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, b_ok, i_ok);
            $display("vec %0d op=%0d a=%h b=%h result=%h lat=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'(vecs[i].special ? SPEC_LAT : FULL_LAT));
            check($sformatf("vec%0d_busy", i), {63'd0, b_ok}, 64'd1);
            check($sformatf("vec%0d_pulse", i), {63'd0, i_ok}, 64'd1);
        end

        // start and operand changes while busy must not disturb the operation
        op = 3'd0; rs1_data = 64'd7; rs2_data = 64'hFFFF_FFFF_FFFF_FFFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        repeat (5) begin @(posedge clk); #1; lat++; end
        rs1_data = 64'd100; rs2_data = 64'd1; op = 3'd5; start = 1'b1;
        repeat (2) begin @(posedge clk); #1; lat++; end
        start = 1'b0;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        $display("busy-start op=0 result=%h lat=%0d", result, lat);
        check("busy_start_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
        check("busy_start_latency", 64'(lat), 64'(FULL_LAT));
        @(posedge clk); #1;

        // reset in the middle of CALC aborts with no done pulse
        op = 3'd0; rs1_data = 64'd9; rs2_data = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid-op reset busy=%0b done=%0b result=%h", busy, done, result);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_result", result, 64'd0);
        saw_done = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("midreset_no_done", {63'd0, saw_done}, 64'd0);

        run_op(3'd0, 64'd5, 64'd6, res, lat, b_ok, i_ok);
        $display("post-reset op=0 a=5 b=6 result=%h lat=%0d", res, lat);
        check("post_reset_mul", res, 64'd30);
        check("post_reset_latency", 64'(lat), 64'(FULL_LAT));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV64M multiply/divide unit between the register file read ports and the write-back mux.
- Consumes the two source operands (ReadData1/ReadData2) and funct3.
- Produces a 64-bit result for the WriteData path.
- Control stalls the PC and holds RegWrite low while busy=1, then writes result on the done pulse.

Parameters:
XLEN, 64, operand/result width in bits; must be even and >= 8
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data  input  XLEN  operand A (multiplicand / dividend)
rs2_data  input  XLEN  operand B (multiplier / divisor)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; held until next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset. Reset wins over every other input.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. Reset mid-operation aborts; no done is produced.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If start=1, latch op, rs1_data, rs2_data.
  - Compute operand magnitudes per signedness: MULH signs both, MULHSU signs A only, DIV/REM sign both, all others unsigned.
  - Record the result-negate flag. Clear the counter. Go to CALC.
- start behaviour: ignored while busy=1. Operands are sampled only at the accepting edge, so later input changes have no effect.
- CALC, multiply:
  - Shift-add over 2*XLEN-bit product register, one multiplier bit per cycle.
  - XLEN cycles, counter increments to XLEN.
- CALC, divide:
  - Restoring division, one quotient bit per cycle, XLEN cycles.
  - Remainder register XLEN+1 bits wide.
- FIX: one cycle. Apply two's-complement negation where required and select the output:
  - MUL: low XLEN bits of product.
  - MULH/MULHSU/MULHU: high XLEN bits of the (signed-corrected) 2*XLEN product.
  - DIV/DIVU quotient: negated if operand signs differ (signed only).
  - REM/REMU remainder: takes the sign of the dividend (signed only).
- DONE: result register loaded, done=1 for exactly this cycle, busy=1. Next state IDLE.
- Latency: done is high in the cycle following the (XLEN+2)th rising edge after the edge that accepted start, i.e. XLEN+3 cycles including the start cycle. A new start may be accepted in the cycle immediately after done.
- Special cases (RISC-V spec results, no exceptions):
  - Divide by zero: DIV/DIVU quotient = all ones. REM/REMU = rs1_data.
  - Signed overflow (A = most-negative, B = -1): DIV = most-negative, REM = 0.
  - Special cases are detected in IDLE and forced in FIX.
- Zero operands and A=B need no special handling and take full latency.

Optional Feature:
MULDIV_FAST_SPECIAL_EN:
- Defined: divide-by-zero and signed-overflow cases skip CALC (IDLE -> FIX -> DONE). done asserts 2 rising edges after the accepting edge. Result values are unchanged.
- Undefined: all operations take full XLEN+2-edge latency.

Test Plan:
- MUL, A=7, B=-3 (0xFFFFFFFFFFFFFFFD), start 1 cycle -> busy next cycle; done after 66 edges; result=0xFFFFFFFFFFFFFFEB; done high exactly 1 cycle.
- MULHU, A=B=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE. MULH on same operands -> result=0x0000000000000000.
- DIV/REM, A=-20, B=3 -> DIV result=-6 (0xFFFFFFFFFFFFFFFA), REM result=-2 (0xFFFFFFFFFFFFFFFE). DIVU with A=20, B=3 -> 6.
- Special cases:
  - DIV A=0x8000000000000000, B=-1 -> 0x8000000000000000; REM -> 0.
  - DIVU A=0x1234, B=0 -> 0xFFFFFFFFFFFFFFFF; REMU -> 0x1234.
  - Latency is 66 edges without MULDIV_FAST_SPECIAL_EN, 2 edges with it.
- Handshake: change rs1_data and pulse start again while busy -> ignored, original result delivered. Back-to-back start in the cycle after done -> accepted.
- Reset mid-op: assert reset at CALC cycle 10 -> next edge busy=0, done=0, result=0; no done pulse follows. Subsequent MUL 5*6 -> 30.
